// File: rtl/shifter_pkg.sv
// Shared types for the iterative shifter: shift-mode encoding and FSM states.
package shifter_pkg;

    typedef enum logic [1:0] {
        SLL = 2'd0,
        SRL = 2'd1,
        SRA = 2'd2,
        ROL = 2'd3
    } shift_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_e;

endpackage

// File: rtl/iterative_shifter_shift_step.sv
// Combinational one-position shift of a WIDTH-bit word, direction and fill chosen by mode.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] data_out
);

    always_comb begin
        data_out = data_in;
        case (shift_mode_e'(mode))
            SLL:     data_out = {data_in[WIDTH-2:0], 1'b0};
            SRL:     data_out = {1'b0, data_in[WIDTH-1:1]};
            SRA:     data_out = {data_in[WIDTH-1], data_in[WIDTH-1:1]};
            ROL:     data_out = {data_in[WIDTH-2:0], data_in[WIDTH-1]};
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: one bit position per clock, start/ready/valid handshake.
//
// state | meaning
// IDLE  | waiting for start, ready=1
// SHIFT | shifting one position per edge, count down to zero, ready=0
// DONE  | one-cycle result_valid pulse, ready=1 (back-to-back accept allowed)
module iterative_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   data_operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               ready,
    output logic               result_valid,
    output logic [WIDTH-1:0]   result
);

    shift_state_e       state_q, state_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    shift_mode_e        mode_q, mode_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   step_out;
    logic               accept;

    shift_step #(.WIDTH(WIDTH)) u_shift_step (
        .data_in  (work_q),
        .mode     (mode_q),
        .data_out (step_out)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            mode_q  <= SLL;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
        end
    end

    // Outputs decode only the state flop, so no input reaches them combinationally.
    assign ready        = (state_q != SHIFT);
    assign result_valid = (state_q == DONE);
    assign result       = work_q;
    assign accept       = start & ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q;
        work_d  = work_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    work_d  = data_operand;
                    mode_d  = shift_mode_e'(mode);
                    count_d = shamt;
                    state_d = (shamt == '0) ? DONE : SHIFT;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d  = step_out;
                count_d = count_q - SHAMT_W'(1);
                if (count_q == SHAMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_iterative_shifter.sv
// Self-checking bench for iterative_shifter: directed vector table, hand-written
// multi-cycle sequences and randomized operations against a plain-arithmetic model.
module tb_iterative_shifter;

    localparam int W = 32;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic [1:0]    mode;
    logic [W-1:0]  data_operand;
    logic [4:0]    shamt;
    logic          ready;
    logic          result_valid;
    logic [W-1:0]  result;

    int checks;
    int failures;

    iterative_shifter #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .mode         (mode),
        .data_operand (data_operand),
        .shamt        (shamt),
        .ready        (ready),
        .result_valid (result_valid),
        .result       (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  m;
        logic [31:0] d;
        int          s;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [31:0] ref_shift(input logic [1:0] m, input logic [31:0] x, input int s);
        logic [31:0] r;
        case (m)
            2'd0: r = x << s;
            2'd1: r = x >> s;
            2'd2: r = $signed(x) >>> s;
            default: r = (s == 0) ? x : ((x << s) | (x >> (32 - s)));
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Runs one operation from an idle/ready state; returns result and latency in cycles
    // (cycle 0 = accept cycle). With perturb set, inputs and start are scrambled mid-flight.
    task automatic run_op(input logic [1:0] m, input logic [31:0] d, input int s,
                          input bit perturb, output logic [31:0] res, output int lat);
        int  c;
        bit  ready_bad;
        res = '0;
        lat = -1;
        ready_bad = 1'b0;
        @(negedge clock);
        check("ready_before_start", {31'd0, ready}, 32'd1);
        start = 1'b1;
        mode = m;
        data_operand = d;
        shamt = 5'(s);
        @(posedge clock);
        #1;
        start = 1'b0;
        if (perturb) begin
            data_operand = $urandom;
            mode = 2'($urandom_range(0, 3));
            shamt = 5'($urandom_range(0, 31));
        end
        for (c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (result_valid) begin
                lat = c;
                res = result;
                check("ready_in_done", {31'd0, ready}, 32'd1);
                break;
            end
            if (ready) ready_bad = 1'b1;
            if (perturb) begin
                data_operand = $urandom;
                mode = 2'($urandom_range(0, 3));
                shamt = 5'($urandom_range(0, 31));
                start = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        check("ready_low_in_shift", {31'd0, ready_bad}, 32'd0);
        if (lat < 0) begin
            failures++;
            $display("FAIL valid_timeout: no result_valid within 40 cycles (shamt=%0d)", s);
        end else begin
            @(negedge clock);
            check("valid_single_pulse", {31'd0, result_valid}, 32'd0);
            check("result_held", result, res);
        end
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        int          pulses;
        logic [31:0] d0, d1, d2;
        logic [1:0]  rm;
        logic [31:0] rd;
        int          rs;

        checks = 0;
        failures = 0;

        vecs[0] = '{2'd0, 32'h0000_0001, 4,  32'h0000_0010};
        vecs[1] = '{2'd2, 32'h8000_00F0, 4,  32'hF800_000F};
        vecs[2] = '{2'd1, 32'h8000_00F0, 4,  32'h0800_000F};
        vecs[3] = '{2'd3, 32'h8000_00F0, 1,  32'h0000_01E1};
        vecs[4] = '{2'd2, 32'hDEAD_BEEF, 0,  32'hDEAD_BEEF};
        vecs[5] = '{2'd0, 32'h0000_0003, 31, 32'h8000_0000};
        vecs[6] = '{2'd3, 32'h8000_0001, 31, 32'hC000_0000};
        vecs[7] = '{2'd2, 32'h4000_0000, 30, 32'h0000_0001};

        reset_n = 1'b0;
        start = 1'b0;
        mode = 2'd0;
        data_operand = '0;
        shamt = '0;
        repeat (3) @(negedge clock);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_valid", {31'd0, result_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (result_valid) pulses++;
        end
        check("no_pulse_before_start", 32'(pulses), 32'd0);
        check("idle_result", result, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].m, vecs[i].d, vecs[i].s, 1'b0, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].s + 1));
        end

        // Back-to-back with start held high; data_operand changed while shifting.
        @(negedge clock);
        d0 = 32'h1234_5678;
        d1 = 32'h0F0F_0F0F;
        d2 = 32'h8000_0003;
        start = 1'b1;
        mode = 2'd0;
        shamt = 5'd2;
        data_operand = d0;
        pulses = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (c == 1) data_operand = d1;
            if (c == 4) data_operand = d2;
            if (c == 9) start = 1'b0;
            if (result_valid) pulses++;
            if (c == 3 || c == 6 || c == 9) begin
                check($sformatf("b2b_valid_c%0d", c), {31'd0, result_valid}, 32'd1);
            end else begin
                check($sformatf("b2b_novalid_c%0d", c), {31'd0, result_valid}, 32'd0);
            end
            if (c == 3) check("b2b_result0", result, ref_shift(2'd0, d0, 2));
            if (c == 6) check("b2b_result1", result, ref_shift(2'd0, d1, 2));
            if (c == 9) check("b2b_result2", result, ref_shift(2'd0, d2, 2));
        end
        check("b2b_pulse_count", 32'(pulses), 32'd3);
        check("b2b_idle_ready", {31'd0, ready}, 32'd1);

        // Reset mid-operation aborts without a result_valid pulse.
        @(negedge clock);
        start = 1'b1;
        mode = 2'd1;
        shamt = 5'd10;
        data_operand = 32'hFFFF_FFFF;
        @(posedge clock);
        #1;
        start = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            if (result_valid) pulses++;
        end
        reset_n = 1'b0;
        #1;
        check("abort_result", result, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_valid", {31'd0, result_valid}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            if (result_valid) pulses++;
        end
        check("abort_no_pulse", 32'(pulses), 32'd0);
        check("abort_result_after", result, 32'd0);

        // Randomized operations with scrambled mid-flight inputs.
        for (int i = 0; i < 40; i++) begin
            rm = 2'($urandom_range(0, 3));
            rd = $urandom;
            rs = $urandom_range(0, 31);
            if (i < 4) rs = (i % 2 == 0) ? 0 : 31;
            run_op(rm, rd, rs, 1'b1, res, lat);
            check($sformatf("rand%0d_result(m=%0d,s=%0d)", i, rm, rs), res, ref_shift(rm, rd, rs));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'(rs + 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
